cache_control: RTL and testbench

- Control FSM for the mp2 L1 cache: 2-way set-associative, write-back, write-allocate, 1-bit LRU per set, 128-bit lines (8 x 16-bit words).
- Sits between the LC-3b CPU memory port and physical memory.
- Drives the cache datapath: way data/tag/valid/dirty/LRU arrays, the line write-merge unit, and the pmem address mux.
- Sequences hit service, dirty-victim writeback and line fill.
- Keeps saturating hit/miss performance counters.

---
 rtl/lc3b_types.sv | 22 ++
 rtl/sat_counter.sv | 20 ++
 rtl/cache_control.sv | 128 ++++++++++++
 tb/tb_cache_control.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b cache types: controller state encoding and cache geometry.
// Pure declarations; no timing or flow-control behaviour.
package lc3b_types;

  typedef enum logic [1:0] {
    CHECK     = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } cache_state_t;

  localparam int WAYS       = 2;
  localparam int LINE_WORDS = 8;

  // One-hot per-way enable from a way index.
  function automatic logic [WAYS-1:0] way_onehot(input logic way);
    logic [WAYS-1:0] oh;
    oh      = '0;
    oh[way] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous active-low clear; +1 per cycle with inc, 1-cycle update.
// No backpressure: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cache_control.sv
// L1 cache control FSM (2-way, write-back, write-allocate); hits answer in the request cycle.
// CPU is held via mem_resp; pmem transactions run until pmem_resp even if the CPU request drops.
module cache_control
  import lc3b_types::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             hit0,
  input  logic             hit1,
  input  logic             lru,
  input  logic             victim_dirty,
  input  logic             pmem_resp,
  output logic             mem_resp,
  output logic             pmem_read,
  output logic             pmem_write,
  output logic             pmem_addr_sel,
  output logic             way_sel,
  output logic [1:0]       load_data,
  output logic             load_tag,
  output logic             set_valid,
  output logic [1:0]       set_dirty,
  output logic             clear_dirty,
  output logic             load_lru,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  cache_state_t state, state_next;
  logic         request;
  logic         hit;
  logic         hit_way;
  logic         hit_inc;
  logic         miss_inc;

  assign request = mem_read | mem_write;
  assign hit     = hit0 | hit1;
  // Both ways matching is illegal; resolve towards way 0.
  assign hit_way = hit1 & ~hit0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= CHECK;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_addr_sel = 1'b0;
    way_sel       = 1'b0;
    load_data     = 2'b00;
    load_tag      = 1'b0;
    set_valid     = 1'b0;
    set_dirty     = 2'b00;
    clear_dirty   = 1'b0;
    load_lru      = 1'b0;
    hit_inc       = 1'b0;
    miss_inc      = 1'b0;

    unique case (state)
      CHECK: begin
        if (request) begin
          if (hit) begin
            mem_resp = 1'b1;
            way_sel  = hit_way;
            load_lru = 1'b1;
            hit_inc  = 1'b1;
            if (mem_write) begin
              load_data = way_onehot(hit_way);
              set_dirty = way_onehot(hit_way);
            end
          end else begin
            miss_inc   = 1'b1;
            state_next = victim_dirty ? WRITEBACK : FILL;
          end
        end
      end

      WRITEBACK: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = 1'b1;
        way_sel       = lru;
        if (pmem_resp) begin
          clear_dirty = 1'b1;
          state_next  = FILL;
        end
      end

      FILL: begin
        pmem_read = 1'b1;
        way_sel   = lru;
        // Fresh line lands clean; the re-check in CHECK applies any write.
        if (pmem_resp) begin
          load_data   = way_onehot(lru);
          load_tag    = 1'b1;
          set_valid   = 1'b1;
          clear_dirty = 1'b1;
          state_next  = CHECK;
        end
      end

      default: state_next = CHECK;
    endcase
  end

  sat_counter #(.CNT_W(CNT_W)) u_hit_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hit_inc),
    .count (hit_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_miss_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (miss_inc),
    .count (miss_count)
  );

endmodule

// File: tb/tb_cache_control.sv
// Directed self-checking bench for cache_control: hit service, clean/dirty misses,
// reset and request drop during fill, and counter saturation.
module tb_cache_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write, hit0, hit1, lru, victim_dirty, pmem_resp;
  logic        mem_resp, pmem_read, pmem_write, pmem_addr_sel, way_sel;
  logic [1:0]  load_data, set_dirty;
  logic        load_tag, set_valid, clear_dirty, load_lru;
  logic [15:0] hit_count, miss_count;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  cache_control #(.CNT_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .hit0          (hit0),
    .hit1          (hit1),
    .lru           (lru),
    .victim_dirty  (victim_dirty),
    .pmem_resp     (pmem_resp),
    .mem_resp      (mem_resp),
    .pmem_read     (pmem_read),
    .pmem_write    (pmem_write),
    .pmem_addr_sel (pmem_addr_sel),
    .way_sel       (way_sel),
    .load_data     (load_data),
    .load_tag      (load_tag),
    .set_valid     (set_valid),
    .set_dirty     (set_dirty),
    .clear_dirty   (clear_dirty),
    .load_lru      (load_lru),
    .hit_count     (hit_count),
    .miss_count    (miss_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    mem_read = 1'b0; mem_write = 1'b0; hit0 = 1'b0; hit1 = 1'b0;
    lru = 1'b0; victim_dirty = 1'b0; pmem_resp = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++; if (hit_count !== 16'd0) $display("FAIL reset_hit_count got %0d exp 0", hit_count); else passed++;
    total++; if (miss_count !== 16'd0) $display("FAIL reset_miss_count got %0d exp 0", miss_count); else passed++;
    total++; if ({mem_resp, pmem_read, pmem_write, load_lru} !== 4'b0000) $display("FAIL reset_ctrl got %b exp 0000", {mem_resp, pmem_read, pmem_write, load_lru}); else passed++;
    total++; if ({load_data, set_dirty, load_tag, set_valid, clear_dirty} !== 7'd0) $display("FAIL reset_loads got %b exp 0000000", {load_data, set_dirty, load_tag, set_valid, clear_dirty}); else passed++;
  endtask

  task automatic test_read_hit();
    do_reset();
    mem_read = 1'b1; hit0 = 1'b1;
    #1;
    total++; if (mem_resp !== 1'b1) $display("FAIL rd_hit_mem_resp got %b exp 1", mem_resp); else passed++;
    total++; if (load_lru !== 1'b1) $display("FAIL rd_hit_load_lru got %b exp 1", load_lru); else passed++;
    total++; if (way_sel !== 1'b0) $display("FAIL rd_hit_way_sel got %b exp 0", way_sel); else passed++;
    total++; if ({load_data, set_dirty} !== 4'b0000) $display("FAIL rd_hit_no_write got %b exp 0000", {load_data, set_dirty}); else passed++;
    tick();
    total++; if (hit_count !== 16'd1) $display("FAIL rd_hit_hit_count got %0d exp 1", hit_count); else passed++;
    total++; if (miss_count !== 16'd0) $display("FAIL rd_hit_miss_count got %0d exp 0", miss_count); else passed++;
    hit1 = 1'b1;
    #1;
    total++; if (way_sel !== 1'b0) $display("FAIL dual_hit_way_sel got %b exp 0", way_sel); else passed++;
    clear_inputs();
  endtask

  task automatic test_write_hit();
    do_reset();
    mem_write = 1'b1; hit1 = 1'b1;
    #1;
    total++; if (load_data !== 2'b10) $display("FAIL wr_hit_load_data got %b exp 10", load_data); else passed++;
    total++; if (set_dirty !== 2'b10) $display("FAIL wr_hit_set_dirty got %b exp 10", set_dirty); else passed++;
    total++; if ({mem_resp, way_sel} !== 2'b11) $display("FAIL wr_hit_resp_way got %b exp 11", {mem_resp, way_sel}); else passed++;
    total++; if ({pmem_read, pmem_write} !== 2'b00) $display("FAIL wr_hit_pmem got %b exp 00", {pmem_read, pmem_write}); else passed++;
    tick();
    total++; if (hit_count !== 16'd1) $display("FAIL wr_hit_hit_count got %0d exp 1", hit_count); else passed++;
    clear_inputs();
  endtask

  task automatic test_read_miss_clean();
    do_reset();
    mem_read = 1'b1; victim_dirty = 1'b0; lru = 1'b0;
    #1;
    total++; if ({mem_resp, pmem_read, pmem_write} !== 3'b000) $display("FAIL rmiss_check got %b exp 000", {mem_resp, pmem_read, pmem_write}); else passed++;
    tick();
    total++; if (miss_count !== 16'd1) $display("FAIL rmiss_miss_count got %0d exp 1", miss_count); else passed++;
    for (int i = 0; i < 5; i++) begin
      pmem_resp = (i == 4);
      #1;
      total++; if ({pmem_read, pmem_write, pmem_addr_sel, mem_resp} !== 4'b1000) $display("FAIL rmiss_fill_%0d got %b exp 1000", i, {pmem_read, pmem_write, pmem_addr_sel, mem_resp}); else passed++;
      if (i == 4) begin
        total++; if ({load_tag, set_valid, clear_dirty, load_data} !== 5'b11101) $display("FAIL rmiss_fill_done got %b exp 11101", {load_tag, set_valid, clear_dirty, load_data}); else passed++;
      end else begin
        total++; if ({load_tag, set_valid, load_data} !== 4'b0000) $display("FAIL rmiss_fill_wait_%0d got %b exp 0000", i, {load_tag, set_valid, load_data}); else passed++;
      end
      tick();
    end
    pmem_resp = 1'b0; hit0 = 1'b1;
    #1;
    total++; if ({mem_resp, pmem_read, load_data} !== 4'b1000) $display("FAIL rmiss_recheck got %b exp 1000", {mem_resp, pmem_read, load_data}); else passed++;
    tick();
    total++; if ({hit_count, miss_count} !== {16'd1, 16'd1}) $display("FAIL rmiss_counts got %0d/%0d exp 1/1", hit_count, miss_count); else passed++;
    clear_inputs();
  endtask

  task automatic test_write_miss_dirty();
    do_reset();
    mem_write = 1'b1; victim_dirty = 1'b1; lru = 1'b1;
    #1;
    total++; if ({mem_resp, pmem_write} !== 2'b00) $display("FAIL wmiss_check got %b exp 00", {mem_resp, pmem_write}); else passed++;
    tick();
    for (int i = 0; i < 3; i++) begin
      pmem_resp = (i == 2);
      #1;
      total++; if ({pmem_write, pmem_read, pmem_addr_sel, way_sel} !== 4'b1011) $display("FAIL wmiss_wb_%0d got %b exp 1011", i, {pmem_write, pmem_read, pmem_addr_sel, way_sel}); else passed++;
      total++; if (clear_dirty !== (i == 2)) $display("FAIL wmiss_wb_clear_%0d got %b exp %b", i, clear_dirty, (i == 2)); else passed++;
      tick();
    end
    pmem_resp = 1'b1;
    #1;
    total++; if ({pmem_read, pmem_write, pmem_addr_sel, way_sel} !== 4'b1001) $display("FAIL wmiss_fill got %b exp 1001", {pmem_read, pmem_write, pmem_addr_sel, way_sel}); else passed++;
    total++; if ({load_data, load_tag, set_valid} !== 4'b1011) $display("FAIL wmiss_fill_load got %b exp 1011", {load_data, load_tag, set_valid}); else passed++;
    tick();
    pmem_resp = 1'b0; hit1 = 1'b1; victim_dirty = 1'b0;
    #1;
    total++; if ({mem_resp, load_data, set_dirty} !== 5'b11010) $display("FAIL wmiss_recheck got %b exp 11010", {mem_resp, load_data, set_dirty}); else passed++;
    tick();
    total++; if ({hit_count, miss_count} !== {16'd1, 16'd1}) $display("FAIL wmiss_counts got %0d/%0d exp 1/1", hit_count, miss_count); else passed++;
    clear_inputs();
  endtask

  task automatic test_reset_mid_fill();
    do_reset();
    mem_read = 1'b1;
    tick();
    tick();
    #1;
    total++; if (pmem_read !== 1'b1) $display("FAIL rstfill_in_fill got %b exp 1", pmem_read); else passed++;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mem_read = 1'b0;
    #1;
    total++; if ({pmem_read, pmem_write, load_tag} !== 3'b000) $display("FAIL rstfill_pmem got %b exp 000", {pmem_read, pmem_write, load_tag}); else passed++;
    total++; if ({hit_count, miss_count} !== 32'd0) $display("FAIL rstfill_counts got %0d/%0d exp 0/0", hit_count, miss_count); else passed++;
    mem_read = 1'b1; hit0 = 1'b1;
    #1;
    total++; if (mem_resp !== 1'b1) $display("FAIL rstfill_check_state got %b exp 1", mem_resp); else passed++;
    clear_inputs();
  endtask

  task automatic test_drop_mid_fill();
    do_reset();
    mem_read = 1'b1;
    tick();
    mem_read = 1'b0;
    tick();
    #1;
    total++; if (pmem_read !== 1'b1) $display("FAIL drop_fill_held got %b exp 1", pmem_read); else passed++;
    pmem_resp = 1'b1;
    #1;
    total++; if ({load_tag, set_valid} !== 2'b11) $display("FAIL drop_fill_done got %b exp 11", {load_tag, set_valid}); else passed++;
    tick();
    pmem_resp = 1'b0;
    #1;
    total++; if ({pmem_read, pmem_write, mem_resp} !== 3'b000) $display("FAIL drop_back_check got %b exp 000", {pmem_read, pmem_write, mem_resp}); else passed++;
    total++; if ({hit_count, miss_count} !== {16'd0, 16'd1}) $display("FAIL drop_counts got %0d/%0d exp 0/1", hit_count, miss_count); else passed++;
    clear_inputs();
  endtask

  task automatic test_saturation();
    do_reset();
    mem_read = 1'b1; hit0 = 1'b1;
    repeat (65534) tick();
    total++; if (hit_count !== 16'hFFFE) $display("FAIL sat_pre got %h exp fffe", hit_count); else passed++;
    tick();
    total++; if (hit_count !== 16'hFFFF) $display("FAIL sat_reach got %h exp ffff", hit_count); else passed++;
    tick();
    total++; if (hit_count !== 16'hFFFF) $display("FAIL sat_hold got %h exp ffff", hit_count); else passed++;
    total++; if (miss_count !== 16'd0) $display("FAIL sat_miss got %0d exp 0", miss_count); else passed++;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b1;
    test_reset();
    test_read_hit();
    test_write_hit();
    test_read_miss_clean();
    test_write_miss_dirty();
    test_reset_mid_fill();
    test_drop_mid_fill();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
